// File: rtl/usb_pkg.sv
// Shared USB line-level types: line symbols, encoder states and the SYNC pattern.
// Also holds the NRZI step and the symbol-to-pin mapping used by the encoder.
package usb_pkg;

    typedef enum logic [1:0] {
        J   = 2'd0,
        K   = 2'd1,
        SE0 = 2'd2
    } line_sym_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC  = 3'd1,
        DATA  = 3'd2,
        SE0_1 = 3'd3,
        SE0_2 = 3'd4,
        EOP_J = 3'd5
    } enc_state_e;

    // Sent LSB first: seven zeros then a one.
    localparam logic [7:0] SYNC_PATTERN = 8'h80;

    // A zero bit flips the held J/K level, a one bit keeps it.
    function automatic line_sym_e nrzi_next(input line_sym_e lvl, input logic b);
        line_sym_e nxt;
        if (b) begin
            nxt = lvl;
        end else if (lvl == J) begin
            nxt = K;
        end else begin
            nxt = J;
        end
        return nxt;
    endfunction

    // Returns {dp, dm}; low-speed devices swap the J and K polarities.
    function automatic logic [1:0] sym_to_line(input line_sym_e s, input logic low_speed);
        logic [1:0] pins;
        case (s)
            J:       pins = low_speed ? 2'b01 : 2'b10;
            K:       pins = low_speed ? 2'b10 : 2'b01;
            default: pins = 2'b00;
        endcase
        return pins;
    endfunction

endpackage

// File: rtl/usb_nrzi_line_encoder.sv
// USB transmit line encoder: SYNC, NRZI-coded packet bits and EOP onto dp/dm,
// advancing one symbol per external bit_tick.
module usb_nrzi_line_encoder
    import usb_pkg::*;
#(
    parameter bit LOW_SPEED = 1'b0
) (
    input  logic clk,
    input  logic RST,
    input  logic bit_tick,
    input  logic tx_start,
    input  logic in_bit,
    input  logic in_valid,
    input  logic in_last,
    output logic in_ready,
    output logic dp,
    output logic dm,
    output logic oe,
    output logic busy,
    output logic underrun
);

    localparam logic [1:0] IDLE_LINE = sym_to_line(J, LOW_SPEED);

    enc_state_e state_q, state_d;
    line_sym_e  level_q, level_d;
    line_sym_e  sym;
    logic       pend_q, pend_d;
    logic [2:0] cnt_q, cnt_d;
    logic [1:0] line_q, line_d;
    logic       oe_q, oe_d;
    logic       underrun_q, underrun_d;
    logic       drive;

    assign in_ready = (state_q == DATA) && bit_tick;
    assign dp       = line_q[1];
    assign dm       = line_q[0];
    assign oe       = oe_q;
    assign busy     = (state_q != IDLE);
    assign underrun = underrun_q;

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        oe_d       = oe_q;
        underrun_d = underrun_q;
        sym        = J;
        drive      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (tx_start) begin
                    pend_d     = 1'b1;
                    underrun_d = 1'b0;
                end
                if (bit_tick) begin
                    drive = 1'b1;
                    if (pend_q) begin
                        pend_d  = 1'b0;
                        level_d = nrzi_next(J, SYNC_PATTERN[0]);
                        sym     = level_d;
                        oe_d    = 1'b1;
                        cnt_d   = 3'd1;
                        state_d = SYNC;
                    end else begin
                        oe_d = 1'b0;
                    end
                end
            end

            SYNC: begin
                if (bit_tick) begin
                    drive   = 1'b1;
                    oe_d    = 1'b1;
                    level_d = nrzi_next(level_q, SYNC_PATTERN[cnt_q]);
                    sym     = level_d;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = DATA;
                    end
                end
            end

            DATA: begin
                if (bit_tick) begin
                    drive = 1'b1;
                    oe_d  = 1'b1;
                    if (in_valid) begin
                        level_d = nrzi_next(level_q, in_bit);
                        sym     = level_d;
                        if (in_last) begin
                            state_d = SE0_1;
                        end
                    end else begin
                        // Starved: this tick already carries the first SE0 of the abort EOP.
                        underrun_d = 1'b1;
                        sym        = SE0;
                        state_d    = SE0_2;
                    end
                end
            end

            SE0_1: begin
                if (bit_tick) begin
                    drive   = 1'b1;
                    oe_d    = 1'b1;
                    sym     = SE0;
                    state_d = SE0_2;
                end
            end

            SE0_2: begin
                if (bit_tick) begin
                    drive   = 1'b1;
                    oe_d    = 1'b1;
                    sym     = SE0;
                    state_d = EOP_J;
                end
            end

            EOP_J: begin
                if (bit_tick) begin
                    drive   = 1'b1;
                    oe_d    = 1'b1;
                    sym     = J;
                    level_d = J;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        line_d = drive ? sym_to_line(sym, LOW_SPEED) : line_q;
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            level_q    <= J;
            pend_q     <= 1'b0;
            cnt_q      <= 3'd0;
            line_q     <= IDLE_LINE;
            oe_q       <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            line_q     <= line_d;
            oe_q       <= oe_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: tb/tb_usb_nrzi_line_encoder.sv
// Scoreboard bench for the USB NRZI line encoder, full-speed and low-speed
// instances driven side by side from one stimulus stream.
module tb_usb_nrzi_line_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bit_tick = 1'b0;
    logic tx_start = 1'b0;
    logic in_bit = 1'b0;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;

    logic rdy_fs, dp_fs, dm_fs, oe_fs, busy_fs, ur_fs;
    logic rdy_ls, dp_ls, dm_ls, oe_ls, busy_ls, ur_ls;

    int n_chk = 0;
    int n_fail = 0;
    int busy_ticks = 0;

    localparam logic [1:0] S_J   = 2'd0;
    localparam logic [1:0] S_K   = 2'd1;
    localparam logic [1:0] S_SE0 = 2'd2;

    typedef struct packed {
        logic [1:0] sym;
        logic       oe;
        logic       rdy;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    usb_nrzi_line_encoder u_fs (
        .clk(clk), .RST(rst), .bit_tick(bit_tick), .tx_start(tx_start),
        .in_bit(in_bit), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy_fs), .dp(dp_fs), .dm(dm_fs), .oe(oe_fs),
        .busy(busy_fs), .underrun(ur_fs)
    );

    usb_nrzi_line_encoder #(.LOW_SPEED(1'b1)) u_ls (
        .clk(clk), .RST(rst), .bit_tick(bit_tick), .tx_start(tx_start),
        .in_bit(in_bit), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy_ls), .dp(dp_ls), .dm(dm_ls), .oe(oe_ls),
        .busy(busy_ls), .underrun(ur_ls)
    );

    function automatic logic [1:0] line_of(input logic [1:0] s, input logic ls);
        if (s == S_SE0) return 2'b00;
        if ((s == S_J) ^ ls) return 2'b10;
        return 2'b01;
    endfunction

    function automatic logic [1:0] tog(input logic [1:0] s);
        return (s == S_J) ? S_K : S_J;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [1:0] s, input logic o, input logic r);
        exp_t e;
        e.sym = s;
        e.oe  = o;
        e.rdy = r;
        exp_q.push_back(e);
    endtask

    // One bit time: tick on one clk, quiet on the next.
    task automatic tick_bit(input logic v, input logic b, input logic l);
        exp_t e;
        logic bb, ba;
        @(negedge clk);
        in_valid = v;
        in_bit   = b;
        in_last  = l;
        bit_tick = 1'b1;
        #1;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        chk("ready_fs", 32'(rdy_fs), 32'(e.rdy));
        chk("ready_ls", 32'(rdy_ls), 32'(e.rdy));
        bb = busy_fs;
        @(posedge clk);
        #1;
        ba = busy_fs;
        chk("line_fs", 32'({dp_fs, dm_fs}), 32'(line_of(e.sym, 1'b0)));
        chk("line_ls", 32'({dp_ls, dm_ls}), 32'(line_of(e.sym, 1'b1)));
        chk("oe_fs", 32'(oe_fs), 32'(e.oe));
        chk("oe_ls", 32'(oe_ls), 32'(e.oe));
        if (bb || ba) busy_ticks++;
        @(negedge clk);
        bit_tick = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_bit   = 1'b0;
    endtask

    // Called on a negedge with bit_tick low; the start lands on a non-tick clk.
    task automatic pulse_start();
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic idle_ticks(input int k);
        for (int i = 0; i < k; i++) begin
            push_exp(S_J, 1'b0, 1'b0);
            tick_bit(1'b1, 1'($urandom), 1'b1);
        end
    endtask

    task automatic send_packet(input logic [15:0] bits, input int n, input int abort_at, input bit poke);
        logic [1:0] lvl;
        logic       b;
        bit         aborted;
        int         acc;
        aborted    = 1'b0;
        acc        = n;
        busy_ticks = 0;
        pulse_start();
        chk("ur_cleared", 32'(ur_fs), 32'd0);
        chk("busy_pending", 32'(busy_fs), 32'd0);
        lvl = S_J;
        for (int i = 0; i < 8; i++) begin
            b   = (i == 7);
            lvl = b ? lvl : tog(lvl);
            push_exp(lvl, 1'b1, 1'b0);
            tick_bit(1'b1, 1'($urandom), 1'b1);
        end
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                push_exp(S_SE0, 1'b1, 1'b1);
                tick_bit(1'b0, bits[i], 1'b0);
                aborted = 1'b1;
                acc     = i;
                break;
            end
            lvl = bits[i] ? lvl : tog(lvl);
            push_exp(lvl, 1'b1, 1'b1);
            tick_bit(1'b1, bits[i], 1'(i == n - 1));
            if (poke && i == 1) pulse_start();
        end
        if (!aborted) begin
            push_exp(S_SE0, 1'b1, 1'b0);
            tick_bit(1'b1, 1'($urandom), 1'b1);
        end
        push_exp(S_SE0, 1'b1, 1'b0);
        tick_bit(1'b1, 1'($urandom), 1'b1);
        if (poke) pulse_start();
        push_exp(S_J, 1'b1, 1'b0);
        tick_bit(1'b1, 1'($urandom), 1'b1);
        push_exp(S_J, 1'b0, 1'b0);
        tick_bit(1'b1, 1'($urandom), 1'b1);
        chk("pkt_len", 32'(busy_ticks), 32'(8 + acc + 3));
        chk("busy_done", 32'(busy_fs), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_line_fs", 32'({dp_fs, dm_fs}), 32'b10);
        chk("rst_line_ls", 32'({dp_ls, dm_ls}), 32'b01);
        chk("rst_oe", 32'(oe_fs), 32'd0);
        chk("rst_busy", 32'(busy_fs), 32'd0);
        chk("rst_ur", 32'(ur_fs), 32'd0);
        rst = 1'b0;
        idle_ticks(2);

        // 0xA5 LSB first with in_last on bit 8
        send_packet(16'h00A5, 8, -1, 1'b0);
        idle_ticks(1);

        // 1111110 from the stuffer: K held for six data ticks, then J
        send_packet(16'h003F, 7, -1, 1'b0);
        idle_ticks(1);

        // starve on the third in_ready
        send_packet(16'h0015, 5, 2, 1'b0);
        chk("ur_set_fs", 32'(ur_fs), 32'd1);
        chk("ur_set_ls", 32'(ur_ls), 32'd1);
        idle_ticks(2);
        chk("ur_sticky", 32'(ur_fs), 32'd1);

        // tx_start during DATA and EOP_J must not queue a second packet
        send_packet(16'h0033, 6, -1, 1'b1);
        idle_ticks(3);
        chk("no_requeue_busy", 32'(busy_fs), 32'd0);

        // reset while the fourth SYNC symbol is on the line
        pulse_start();
        begin
            logic [1:0] lvl;
            lvl = S_J;
            for (int i = 0; i < 4; i++) begin
                lvl = tog(lvl);
                push_exp(lvl, 1'b1, 1'b0);
                tick_bit(1'b1, 1'b0, 1'b0);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_oe", 32'(oe_fs), 32'd0);
        chk("midrst_line_fs", 32'({dp_fs, dm_fs}), 32'b10);
        chk("midrst_line_ls", 32'({dp_ls, dm_ls}), 32'b01);
        chk("midrst_busy", 32'(busy_fs), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_ticks(4);
        chk("post_rst_busy", 32'(busy_fs), 32'd0);
        send_packet(16'h00C3, 8, -1, 1'b0);
        idle_ticks(1);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_nrzi_line_encoder.md
USB_NRZI_LINE_ENCODER -- requirements
Module: usb_nrzi_line_encoder

Interface
REQ-001 SHALL have parameter LOW_SPEED, default 0, meaning 0 = full-speed J/K polarity and 1 = low-speed (J/K swapped).
REQ-002 SHALL have port clk, input, 1, system clock; all logic is on its rising edge.
REQ-003 SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port bit_tick, input, 1, one-clk strobe per USB bit time; outputs change only on ticks.
REQ-005 SHALL have port tx_start, input, 1, packet-start request, sampled only in IDLE.
REQ-006 SHALL have port in_bit, input, 1, stuffed data bit from the bit stuffer.
REQ-007 SHALL have port in_valid, input, 1, qualifies in_bit on an in_ready clk.
REQ-008 SHALL have port in_last, input, 1, marks the qualified bit as the final packet bit.
REQ-009 SHALL have port in_ready, output, 1, combinational, equals (state==DATA && bit_tick).
REQ-010 SHALL have port dp, output, 1, registered D+ line level.
REQ-011 SHALL have port dm, output, 1, registered D- line level.
REQ-012 SHALL have port oe, output, 1, registered transceiver output enable.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 SHALL have port underrun, output, 1, sticky error flag, cleared by the next accepted tx_start.

Function
REQ-015 SHALL implement states IDLE, SYNC, DATA, SE0_1, SE0_2, EOP_J.
REQ-016 SHALL define line symbols for full speed as J={dp=1,dm=0}, K={0,1}, SE0={0,0}; when LOW_SPEED=1, J and K SHALL be swapped.
REQ-017 IDLE: oe=0, line=J; tx_start=1 on any clk SHALL latch a pending start; the next bit_tick SHALL enter SYNC and drive its first bit.
REQ-018 SYNC: SHALL send the 8-bit pattern 0000_0001, sent first to last, NRZI-encoded, as K J K J K J K K, one symbol per tick, with oe=1; 3-bit counter; after bit 8 SHALL enter DATA.
REQ-019 NRZI rule: bit 0 SHALL toggle the held J/K level and bit 1 SHALL hold it; the held level SHALL be K on entering DATA.
REQ-020 DATA: on each in_ready clk with in_valid=1, SHALL drive the NRZI of in_bit on that tick; if in_last=1, SHALL go to SE0_1 at the next tick.
REQ-021 DATA underrun: in_ready with in_valid=0 SHALL set underrun, drive no data bit, and enter SE0_1 at that same tick (abort with EOP).
REQ-022 SE0_1 and SE0_2: each SHALL drive SE0 with oe=1 for one bit time.
REQ-023 EOP_J: SHALL drive J with oe=1 for one bit time, then enter IDLE with oe=0 and line=J.
REQ-024 tx_start while busy SHALL be ignored and SHALL NOT be queued.
REQ-025 in_bit, in_valid and in_last SHALL be ignored outside in_ready clks.
REQ-026 Packet length SHALL be 8 + N + 3 bit times for N accepted data bits.

Reset
REQ-027 RST=1 SHALL immediately force IDLE, oe=0, dp/dm=J, busy=0, underrun=0, the held NRZI level to J, the SYNC counter to 0 and the pending start to 0, including mid-packet.
REQ-028 After RST deasserts, no transmission SHALL start without a new tx_start.

Structure
REQ-029 Shared package usb_pkg SHALL hold the line-symbol enum (J, K, SE0), the encoder state enum, and the constant SYNC_PATTERN = 8'h80 (LSB-first).
REQ-030 The block SHALL be a single module with no sub-module; bit_tick generation SHALL be external.

Verification
REQ-031 tx_start, then 8 data bits 0xA5 LSB-first with in_last on bit 8 -> KJKJKJKK, NRZI of 1,0,1,0,0,1,0,1 = K J J K J J K K, then SE0, SE0, J, then oe=0.
REQ-032 Data bits 1111110, as stuffed by the upstream stuffer -> line holds K for 6 ticks, then J; busy for 18 ticks.
REQ-033 in_valid=0 on the 3rd in_ready -> underrun=1, SE0 on that tick, 2 data bits on the line; the next tx_start clears underrun.
REQ-034 RST asserted during SYNC bit 4 -> same clk: oe=0, dp=1, dm=0, busy=0; no activity until a new tx_start.
REQ-035 LOW_SPEED=1, same stimulus as REQ-031 -> every dp/dm pair inverted except SE0; idle dp=0, dm=1.
REQ-036 tx_start pulsed during DATA and during EOP_J -> ignored; IDLE is reached after the first packet's EOP with no second SYNC.
